xb_stream_framer: RTL

- Sits directly upstream of the 32-bit host-read FIFO (fifo_32x512 write side) on bus_clk.
- Takes a raw 32-bit sample stream from detector/user logic with a valid/ready handshake.
- Wraps fixed-length groups of samples into frames (header, payload, trailer) so host software reading the 32-bit Xillybus read stream can resynchronise and check integrity.

---
 rtl/xb_pkg.sv | 18 +
 rtl/xb_fold_checksum.sv | 22 ++
 rtl/xb_stream_framer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/xb_pkg.sv
// rtl/xb_pkg.sv - shared types, constants and helpers for the stream framer
package xb_pkg;

    localparam logic [15:0] XB_HDR_MAGIC = 16'hCE9C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_TSTAMP,
        ST_PAYLOAD,
        ST_TRAILER
    } state_t;

    function automatic logic [15:0] fold16(input logic [31:0] word);
        return word[31:16] ^ word[15:0];
    endfunction

endpackage

// File: rtl/xb_fold_checksum.sv
// rtl/xb_fold_checksum.sv - 16-bit XOR-fold accumulator with clear and enable
module xb_fold_checksum
    import xb_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] din,
    output logic [15:0] sum
);

    // clear wins over en so a new frame always starts from zero
    always_ff @(posedge clk) begin
        if (srst || clear) begin
            sum <= 16'h0000;
        end else if (en) begin
            sum <= sum ^ fold16(din);
        end
    end

endmodule

// File: rtl/xb_stream_framer.sv
// rtl/xb_stream_framer.sv - frames a 32-bit sample stream into header/payload/trailer FIFO writes
// Optional timestamp word after the header: XB_FRAMER_TIMESTAMP_EN
module xb_stream_framer
    import xb_pkg::*;
#(
    parameter int          LEN_W     = 16,
    parameter logic [15:0] HDR_MAGIC = XB_HDR_MAGIC
) (
    input  logic             bus_clk,
    input  logic             srst,
    input  logic             enable,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [31:0]      fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full,
    output logic [31:0]      frames_sent,
    output logic             busy
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] seq;
    logic [15:0]      csum;
    logic             start;
    logic             pay_wr;

`ifdef XB_FRAMER_TIMESTAMP_EN
    logic [31:0] cyc;
    logic [31:0] ts;

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            cyc <= 32'h0;
            ts  <= 32'h0;
        end else begin
            cyc <= cyc + 32'h1;
            if (start) begin
                ts <= cyc;
            end
        end
    end
`endif

    assign start  = (state == ST_IDLE) && enable && s_valid;
    assign pay_wr = (state == ST_PAYLOAD) && s_valid && !fifo_full && !srst;

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_din   = 32'h0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                fifo_din   = {HDR_MAGIC, 16'(seq)};
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
`ifdef XB_FRAMER_TIMESTAMP_EN
                    state_next = ST_TSTAMP;
`else
                    state_next = ST_PAYLOAD;
`endif
                end
            end
`ifdef XB_FRAMER_TIMESTAMP_EN
            ST_TSTAMP: begin
                fifo_din   = ts;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    state_next = ST_PAYLOAD;
                end
            end
`endif
            ST_PAYLOAD: begin
                s_ready    = !fifo_full;
                fifo_din   = s_data;
                fifo_wr_en = s_valid && !fifo_full;
                if (s_valid && !fifo_full && (cnt == len - LEN_ONE)) begin
                    state_next = ST_TRAILER;
                end
            end
            ST_TRAILER: begin
                fifo_din   = {16'(len), csum};
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // reset forces every output quiet even before the state register clears
        if (srst) begin
            s_ready    = 1'b0;
            fifo_wr_en = 1'b0;
            fifo_din   = 32'h0;
        end
    end

    assign busy = (state != ST_IDLE) && !srst;

    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state       <= ST_IDLE;
            len         <= '0;
            cnt         <= '0;
            seq         <= '0;
            frames_sent <= 32'h0;
        end else begin
            state <= state_next;
            if (start) begin
                len <= (frame_len == '0) ? LEN_ONE : frame_len;
                cnt <= '0;
            end else if (pay_wr) begin
                cnt <= cnt + LEN_ONE;
            end
            if ((state == ST_TRAILER) && !fifo_full) begin
                seq         <= seq + LEN_ONE;
                frames_sent <= frames_sent + 32'h1;
            end
        end
    end

    xb_fold_checksum u_csum (
        .clk  (bus_clk),
        .srst (srst),
        .clear(start),
        .en   (pay_wr),
        .din  (s_data),
        .sum  (csum)
    );

endmodule
